// File: rtl/insn_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The master side is the stream source and memory; the slave side is the loader.
interface insn_loader_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] addr;
    logic [31:0] din;
    logic        we;

    modport master (output s_data, s_valid, input s_ready, addr, din, we);
    modport slave  (input s_data, s_valid, output s_ready, addr, din, we);
endinterface

// File: rtl/insn_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> 32-bit instruction
// memory writes from address 0; holds the core in reset until the image is complete.
module insn_loader #(
    parameter int DEPTH = 12
) (
    input  logic         clk,
    input  logic         reset,
    insn_loader_if.slave bus,
    output logic         core_reset,
    output logic         done,
    output logic         error
);
    typedef enum logic [2:0] {HDR, DATA, WRITE, RUN, ERR} state_t;

    localparam int          WW  = DEPTH - 1;
    localparam logic [31:0] CAP = 32'd1 << (DEPTH - 2);

    state_t        state, state_n;
    logic [1:0]    bcnt, bcnt_n;
    logic [31:0]   len, len_n;
    logic [WW-1:0] widx, widx_n;
    logic [31:0]   addr_n, din_n, hdr;
    logic          we_n, core_reset_n, done_n, error_n;
    logic          take;

    assign bus.s_ready = (state == HDR) || (state == DATA) || (state == RUN);
    assign take        = bus.s_valid && bus.s_ready;
    // Full 32-bit length as it will be once the current (last) header byte lands.
    assign hdr         = {bus.s_data, len[23:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HDR;
            bcnt       <= '0;
            len        <= '0;
            widx       <= '0;
            bus.we     <= 1'b0;
            bus.addr   <= '0;
            bus.din    <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            bcnt       <= bcnt_n;
            len        <= len_n;
            widx       <= widx_n;
            bus.we     <= we_n;
            bus.addr   <= addr_n;
            bus.din    <= din_n;
            core_reset <= core_reset_n;
            done       <= done_n;
            error      <= error_n;
        end
    end

    always_comb begin
        state_n      = state;
        bcnt_n       = bcnt;
        len_n        = len;
        widx_n       = widx;
        addr_n       = bus.addr;
        din_n        = bus.din;
        we_n         = 1'b0;
        done_n       = 1'b0;
        core_reset_n = core_reset;
        error_n      = error;
        case (state)
            HDR: if (take) begin
                len_n[{bcnt, 3'b000} +: 8] = bus.s_data;
                bcnt_n = bcnt + 2'd1;
                if (bcnt == 2'd3) begin
                    widx_n = '0;
                    if (hdr == 32'd0) begin
                        state_n      = RUN;
                        done_n       = 1'b1;
                        core_reset_n = 1'b0;
                    end else if (hdr > CAP) begin
                        state_n = ERR;
                        error_n = 1'b1;
                    end else begin
                        state_n = DATA;
                    end
                end
            end
            DATA: if (take) begin
                din_n[{bcnt, 3'b000} +: 8] = bus.s_data;
                bcnt_n = bcnt + 2'd1;
                if (bcnt == 2'd3) begin
                    state_n = WRITE;
                    we_n    = 1'b1;
                    addr_n  = 32'({widx, 2'b00});
                end
            end
            WRITE: begin
                // len >= 1 here, so len-1 cannot wrap.
                if (32'(widx) == len - 32'd1) begin
                    state_n      = RUN;
                    done_n       = 1'b1;
                    core_reset_n = 1'b0;
                end else begin
                    widx_n  = widx + 1'b1;
                    state_n = DATA;
                end
            end
            RUN: if (take) begin
                // First byte of a new image is header byte 0.
                state_n      = HDR;
                len_n        = {24'd0, bus.s_data};
                bcnt_n       = 2'd1;
                core_reset_n = 1'b1;
            end
            ERR: ;
            default: state_n = HDR;
        endcase
    end
endmodule

// File: doc/insn_loader.md
# insn_loader

Byte-stream boot loader that fills the core's instruction memory before execution starts. It accepts a length-prefixed little-endian byte stream on a valid/ready port and assembles 32-bit words. It drives the instruction memory write port (`addr`/`din`/`we`) with consecutive word addresses from 0, and holds the core in reset until the image is complete.

## Interface

- `DEPTH`, 12, byte-address width of the instruction memory; capacity `CAP = 2**(DEPTH-2)` words.

Ports:

- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `s_data` in 8: stream byte.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: loader accepts a byte this cycle.
- `addr` out 32: instruction memory write byte address.
- `din` out 32: instruction memory write data.
- `we` out 1: instruction memory write enable, one cycle per word.
- `core_reset` out 1: holds the core in reset while no valid image is loaded.
- `done` out 1: one-cycle pulse when a load completes.
- `error` out 1: sticky flag, set when the header length exceeds `CAP`.

## Operation

- Byte transfer occurs on a rising edge with `s_valid && s_ready`. Bytes arriving while `s_ready=0` are not consumed; the source holds them.
- Stream format: 4-byte little-endian length `N` in words, then `N` words. Each word is 4 bytes, least-significant byte first.
- States:
  - HDR: accept 4 header bytes.
  - DATA: accept 4 data bytes.
  - WRITE: issue one memory write.
  - RUN: image loaded.
  - ERR: header length out of range.
- HDR:
  - `s_ready=1`; byte counter 0..3.
  - On the 4th byte, `N` is latched.
  - `N==0` → RUN.
  - `N>CAP` → ERR.
  - Otherwise → DATA with word index 0.
  - `N==CAP` is legal.
- DATA:
  - `s_ready=1`.
  - Byte k (k = 0..3) is stored into `din[8k+7:8k]`.
  - On the 4th byte → WRITE.
- WRITE:
  - `s_ready=0`, `we=1`, `addr = word_index*4` (bits above `DEPTH-1` zero), `din` = assembled word.
  - Next state: if `word_index == N-1` → RUN, else `word_index+1` → DATA.
- RUN:
  - `core_reset=0`, `s_ready=1`.
  - Any accepted byte is header byte 0 of a new image. The loader enters HDR with byte counter 1 and re-asserts `core_reset` from the next cycle.
- ERR:
  - `s_ready=0`, `error=1`, `core_reset=1`.
  - Only `reset` leaves ERR.
- `core_reset=1` in HDR, DATA, WRITE and ERR.
- `we=0` in every state except WRITE. `addr`/`din` are don't-care when `we=0` but must be registered (no glitching combinational paths from `s_data`).
- Word index counter is `DEPTH-1` bits wide. Length register compares all 32 header bits against `CAP`, so no truncation occurs before the compare.

## Timing

- All outputs are registered from state, except `s_ready`, which is decoded from the current state only; `s_ready` never depends on `s_valid`.
- Reset values:
  - state HDR, so `s_ready=1`.
  - `we=0`, `addr=0`, `din=0`.
  - `core_reset=1`, `done=0`, `error=0`.
  - All counters 0.
- Latency, 4th data byte accepted at edge T:
  - `we=1` during cycle T..T+1.
  - Memory captures on edge T+1.
  - `s_ready` returns to 1 at T+1 (or RUN if last).
- Peak throughput is one word per 5 cycles.
- Last word written at edge T+1:
  - RUN entered at T+1.
  - `done=1` and `core_reset=0` during cycle T+1..T+2.
  - `done` is low thereafter.
- `N==0`:
  - RUN entered on the edge accepting header byte 3.
  - `done` pulses in that first RUN cycle.
  - No `we` pulse.
- Overflow:
  - ERR entered on the edge accepting header byte 3.
  - `error` high from that cycle on.
  - No `we` pulse, no `done`.
- Idle gaps (`s_valid=0`) stall counters with state and partial word preserved.
- Asynchronous reset mid-load:
  - Returns to HDR immediately: `core_reset=1`, `we=0`, `error=0`.
  - Partial data is discarded.
  - Memory contents already written are left untouched.

## Test plan

- Basic load, `DEPTH=12`, stream `02 00 00 00, 13 00 00 00, 6F 00 00 00` → `we` pulses with (`addr=0`, `din=0x00000013`) then (`addr=4`, `din=0x0000006F`). `done` pulses once, 1 cycle after the second write. `core_reset` falls with `done`. Readback via the memory read port matches.
- Zero length: header `00 00 00 00` → no `we`; `done` pulses and `core_reset=0` in the cycle after header byte 3.
- Capacity boundary, `DEPTH=4` (`CAP=4`):
  - `N=4` → 4 writes at `addr` 0, 4, 8, 12, then `done`.
  - `N=5` → `error=1`, `s_ready=0`, no writes, `core_reset` stays 1 until `reset`.
- Back-pressure and gaps: random `s_valid` deasserts, including during WRITE (`s_ready=0`) → no byte lost or duplicated; words are identical to the gap-free run.
- Reload: after RUN, send a second image `01 00 00 00, EF BE AD DE` → `core_reset` re-asserts the cycle after the first byte; one write `addr=0`, `din=0xDEADBEEF`; `done` pulses.
- Reset mid-load: assert `reset` after 2 data bytes of word 1 → outputs return to reset values immediately. A fresh full image then loads correctly from `addr=0`.
